// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Two independent push-button debouncers; each emits a
//               registered one-cycle pulse per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic leftBtn,
    input  logic rightBtn,
    output logic leftBtnDebounce,
    output logic rightBtnDebounce
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] c_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_pulse;

    assign w_raw            = {rightBtn, leftBtn};
    assign leftBtnDebounce  = w_pulse[0];
    assign rightBtnDebounce = w_pulse[1];

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic          s1_q;
        logic          s2_q;
        logic [CW-1:0] cnt_q;
        logic          pulse_q;
        state_t        state_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                state_q <= IDLE;
            end else begin
                s1_q    <= w_raw[g];
                s2_q    <= s1_q;
                pulse_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (s2_q) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s2_q) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == c_CNT_MAX) begin
                            state_q <= HELD;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!s2_q) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        // A bounce back high re-enters HELD without a new pulse
                        if (s2_q) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == c_CNT_MAX) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign w_pulse[g] = pulse_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module      : tb_button_debouncer
// Description : Directed-vector bench for button_debouncer (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debouncer;

    localparam int c_N = 4;

    logic clk;
    logic reset;
    logic r_left;
    logic r_right;
    logic w_left_pulse;
    logic w_right_pulse;

    int n_checks;
    int n_fail;

    button_debouncer #(
        .DEBOUNCE_CYCLES(c_N)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .leftBtn          (r_left),
        .rightBtn         (r_right),
        .leftBtnDebounce  (w_left_pulse),
        .rightBtnDebounce (w_right_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive the buttons for a number of cycles; cycle k is sampled #1 after
    // the k-th edge of this segment (k=0 is the edge that first samples it).
    task automatic apply(input string tag, input logic l, input logic r,
                         input int cycles, input int l_at, input int r_at);
        r_left  = l;
        r_right = r;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_left"},  w_left_pulse,  logic'(k == l_at));
            check_eq({tag, "_right"}, w_right_pulse, logic'(k == r_at));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        r_left   = 1'b0;
        r_right  = 1'b0;
        #2;
        check_eq("reset_left",  w_left_pulse,  1'b0);
        check_eq("reset_right", w_right_pulse, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        apply("idle", 1'b0, 1'b0, 5, -1, -1);

        // Clean press, pulse after E0+N+2
        apply("clean",     1'b1, 1'b0, 20, c_N + 2, -1);
        apply("clean_rel", 1'b0, 1'b0, 20, -1, -1);

        // Press bounce 1,1,0,1,0 then steady high
        apply("pb_a", 1'b1, 1'b0, 2, -1, -1);
        apply("pb_b", 1'b0, 1'b0, 1, -1, -1);
        apply("pb_c", 1'b1, 1'b0, 1, -1, -1);
        apply("pb_d", 1'b0, 1'b0, 1, -1, -1);
        apply("pb_hold", 1'b1, 1'b0, 20, c_N + 2, -1);
        apply("pb_rel",  1'b0, 1'b0, 20, -1, -1);

        // Glitch shorter than the debounce window
        apply("glitch",     1'b1, 1'b0, 3, -1, -1);
        apply("glitch_low", 1'b0, 1'b0, 20, -1, -1);
        apply("post_glitch", 1'b1, 1'b0, 20, c_N + 2, -1);

        // Release bounce: low 2, high 2, low 20 -> no second pulse
        apply("rb_low1", 1'b0, 1'b0, 2, -1, -1);
        apply("rb_high", 1'b1, 1'b0, 2, -1, -1);
        apply("rb_low2", 1'b0, 1'b0, 20, -1, -1);
        apply("rb_next", 1'b1, 1'b0, 20, c_N + 2, -1);
        apply("rb_rel",  1'b0, 1'b0, 20, -1, -1);

        // Right channel alone, then both together
        apply("right_only", 1'b0, 1'b1, 20, -1, c_N + 2);
        apply("right_rel",  1'b0, 1'b0, 20, -1, -1);
        apply("both",       1'b1, 1'b1, 20, c_N + 2, c_N + 2);
        apply("both_rel",   1'b0, 1'b0, 20, -1, -1);

        // Reset 3 cycles into a press, released with the button still high
        apply("rst_pre", 1'b1, 1'b0, 3, -1, -1);
        reset = 1'b1;
        #1;
        check_eq("rst_async_left", w_left_pulse, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_left", w_left_pulse, 1'b0);
        end
        reset = 1'b0;
        apply("rst_post", 1'b1, 1'b0, 20, c_N + 2, -1);
        apply("rst_rel",  1'b0, 1'b0, 20, -1, -1);

        // Reset landing in the pulse cycle kills the pulse immediately
        apply("rp_pre", 1'b1, 1'b0, c_N + 2, -1, -1);
        @(posedge clk);
        #1;
        check_eq("rp_pulse_high", w_left_pulse, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("rp_pulse_abort", w_left_pulse, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply("rp_post", 1'b1, 1'b0, 20, c_N + 2, -1);
        apply("rp_rel",  1'b0, 1'b0, 10, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
